// File: rtl/bus_pkg.sv
// Shared types for the bus transaction controller: FSM states, engine selects
// and the layout of a buffered command.
package bus_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, REQ, RSP} state_t;

    localparam logic [2:0] SEL_UART = 3'b001;
    localparam logic [2:0] SEL_SPI  = 3'b010;
    localparam logic [2:0] SEL_I2C  = 3'b100;

    localparam int SEL_W_DEF  = 3;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 8;

    // Default-width command record; the top re-declares it at its own widths.
    typedef struct packed {
        logic [SEL_W_DEF-1:0]  sel;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
        logic                  rw;
    } cmd_entry_t;

endpackage

// File: rtl/bus_cmd_fifo.sv
// Show-ahead synchronous FIFO for pending commands; head is readable
// combinationally so the controller can pop and register in one cycle.
module bus_cmd_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign rdata   = mem[rd_ptr];

    // Pointers are exactly AW bits wide so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/bus_txn_ctrl.sv
// Buffers engine commands and issues them one at a time over a req/ack
// handshake with timeout, returning a response record per command.
module bus_txn_ctrl
    import bus_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int SEL_W   = SEL_W_DEF,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [SEL_W-1:0]         cmd_sel,
    input  logic [ADDR_W-1:0]        cmd_addr,
    input  logic [DATA_W-1:0]        cmd_data,
    input  logic                     cmd_rw,
    output logic [SEL_W-1:0]         select_p,
    output logic [ADDR_W-1:0]        address,
    output logic [DATA_W-1:0]        data,
    output logic                     rw,
    output logic                     req,
    input  logic                     ack,
    input  logic                     err,
    input  logic [DATA_W-1:0]        received_data,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic                     rsp_timeout,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    localparam int EW = SEL_W + ADDR_W + DATA_W + 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              rw;
    } entry_t;

    state_t          state;
    entry_t          push_ent, head;
    logic            rst_done, full, empty, pop, head_ok, tmo_hit;
    logic [TW-1:0]   tmo_cnt;

    assign push_ent  = '{sel: cmd_sel, addr: cmd_addr, data: cmd_data, rw: cmd_rw};
    // Held low while in reset and for the first cycle after release.
    assign cmd_ready = rst_done & ~full;
    assign pop       = (state == IDLE) & ~empty;
    assign head_ok   = (head.sel != '0) && ((head.sel & (head.sel - 1'b1)) == '0);
    assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT - 1));
    assign busy      = (state != IDLE) | ~empty;

    bus_cmd_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cmd_valid & cmd_ready),
        .wdata (push_ent),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            rst_done    <= 1'b0;
            select_p    <= '0;
            address     <= '0;
            data        <= '0;
            rw          <= 1'b0;
            req         <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_data    <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            rst_done <= 1'b1;
            case (state)
                IDLE: begin
                    if (!empty) begin
                        address <= head.addr;
                        data    <= head.data;
                        rw      <= head.rw;
                        if (head_ok) begin
                            select_p <= head.sel;
                            state    <= SETUP;
                        end else begin
                            rsp_valid   <= 1'b1;
                            rsp_err     <= 1'b1;
                            rsp_timeout <= 1'b0;
                            rsp_data    <= '0;
                            state       <= RSP;
                        end
                    end
                end
                SETUP: begin
                    req     <= 1'b1;
                    tmo_cnt <= '0;
                    state   <= REQ;
                end
                REQ: begin
                    // err beats ack, and either beats a same-cycle timeout.
                    if (err) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end else if (ack) begin
                        rsp_err  <= 1'b0;
                        rsp_data <= rw ? received_data : '0;
                    end else if (tmo_hit) begin
                        rsp_err     <= 1'b1;
                        rsp_timeout <= 1'b1;
                        rsp_data    <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    if (err || ack || tmo_hit) begin
                        req       <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid   <= 1'b0;
                        rsp_err     <= 1'b0;
                        rsp_timeout <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_txn_ctrl.sv
// Directed bench for bus_txn_ctrl with a small engine model and an
// expected-issue / expected-response scoreboard.
module tb_bus_txn_ctrl;
    import bus_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0, cmd_ready;
    logic [2:0] cmd_sel = '0;
    logic [6:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       cmd_rw = 1'b0;
    logic [2:0] select_p;
    logic [6:0] address;
    logic [7:0] data;
    logic       rw, req;
    logic       ack = 1'b0, err = 1'b0;
    logic [7:0] received_data = '0;
    logic       rsp_valid, rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic       rsp_err, rsp_timeout, busy;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    bus_txn_ctrl #(.TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_sel(cmd_sel),
        .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_rw(cmd_rw),
        .select_p(select_p), .address(address), .data(data), .rw(rw), .req(req),
        .ack(ack), .err(err), .received_data(received_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .fifo_count(fifo_count)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic [6:0] addr;
        logic [7:0] data;
        logic       rw;
    } iss_t;
    typedef struct packed {
        logic [7:0] data;
        logic       err;
        logic       tmo;
    } rsp_t;

    iss_t iss_q[$];
    rsp_t rsp_q[$];
    iss_t last_iss;
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] s, input logic [6:0] a, input logic [7:0] d,
                        input logic r, input bit legal);
        int n = 0;
        cmd_valid = 1'b1; cmd_sel = s; cmd_addr = a; cmd_data = d; cmd_rw = r;
        while (!cmd_ready && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) chk("push_ready", 32'(cmd_ready), 32'(1));
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        if (legal) iss_q.push_back('{sel: s, addr: a, data: d, rw: r});
        else       rsp_q.push_back('{data: 8'h00, err: 1'b1, tmo: 1'b0});
    endtask

    task automatic wait_req();
        int n = 0;
        while (!req && n < 100) begin @(negedge clk); n++; end
        chk("req_rise", 32'(req), 32'(1));
        if (req && iss_q.size() > 0) begin
            last_iss = iss_q.pop_front();
            chk("iss_sel",  32'(select_p), 32'(last_iss.sel));
            chk("iss_addr", 32'(address),  32'(last_iss.addr));
            chk("iss_data", 32'(data),     32'(last_iss.data));
            chk("iss_rw",   32'(rw),       32'(last_iss.rw));
        end
    endtask

    // Engine model: holds ack/err off until req has been high for `hold` cycles.
    task automatic serve(input int hold, input logic a, input logic e, input logic [7:0] rd);
        int cnt = 1;
        while (cnt < hold) begin
            @(negedge clk);
            chk("req_hold", 32'(req), 32'(1));
            cnt++;
        end
        ack = a; err = e; received_data = rd;
        if (e)      rsp_q.push_back('{data: 8'h00, err: 1'b1, tmo: 1'b0});
        else if (a) rsp_q.push_back('{data: last_iss.rw ? rd : 8'h00, err: 1'b0, tmo: 1'b0});
        @(posedge clk); #1;
        ack = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("req_drop", 32'(req), 32'(0));
    endtask

    task automatic rsp_check(input int hold, output int req_hits);
        int   n = 0;
        rsp_t e;
        req_hits = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            if (req) req_hits++;
            n++;
        end
        chk("rsp_valid", 32'(rsp_valid), 32'(1));
        e = '0;
        if (rsp_q.size() > 0) e = rsp_q.pop_front();
        chk("rsp_data", 32'(rsp_data),    32'(e.data));
        chk("rsp_err",  32'(rsp_err),     32'(e.err));
        chk("rsp_tmo",  32'(rsp_timeout), 32'(e.tmo));
        repeat (hold) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            chk("rsp_hold", 32'({rsp_valid, rsp_err, rsp_data}), 32'({1'b1, e.err, e.data}));
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("rsp_clear", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'(0));
        chk("rsp_data_keep", 32'(rsp_data), 32'(e.data));
    endtask

    initial begin
        int rh, n, seen_req, seen_rsp;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req",   32'(req), 32'(0));
        chk("rst_rspv",  32'(rsp_valid), 32'(0));
        chk("rst_ready", 32'(cmd_ready), 32'(0));
        chk("rst_outs",  32'({select_p, address, data, rw}), 32'(0));
        chk("rst_rsp",   32'({rsp_data, rsp_err, rsp_timeout}), 32'(0));
        chk("rst_busy",  32'({busy, fifo_count}), 32'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("ready_after_rst", 32'(cmd_ready), 32'(1));

        // ack/err while idle must be ignored
        ack = 1'b1; err = 1'b1;
        @(negedge clk);
        ack = 1'b0; err = 1'b0;
        @(negedge clk);
        chk("idle_ack_ignored", 32'({rsp_valid, busy}), 32'(0));

        // Write to UART: latency N+1 register, N+2 req, ack after 3 req cycles
        push(SEL_UART, 7'h42, 8'hA4, 1'b0, 1'b1);
        @(negedge clk);
        chk("lat_req_n0", 32'(req), 32'(0));
        chk("lat_cnt_n0", 32'({busy, fifo_count}), 32'({1'b1, 3'd1}));
        @(negedge clk);
        chk("lat_req_n1", 32'(req), 32'(0));
        chk("lat_cnt_n1", 32'(fifo_count), 32'(0));
        chk("lat_reg_n1", 32'({select_p, address, data}), 32'({SEL_UART, 7'h42, 8'hA4}));
        @(negedge clk);
        chk("lat_req_n2", 32'(req), 32'(1));
        wait_req();
        serve(3, 1'b1, 1'b0, 8'hFF);
        rsp_check(0, rh);

        // Read from I2C, response held 4 cycles
        push(SEL_I2C, 7'h21, 8'h00, 1'b1, 1'b1);
        wait_req();
        serve(2, 1'b1, 1'b0, 8'h5C);
        rsp_check(4, rh);

        // Fill: 5 back-to-back commands, first already popped when the 5th lands
        for (int i = 0; i < 5; i++)
            push((i % 2 == 0) ? SEL_SPI : SEL_UART, 7'(7'h10 + i), 8'(8'hC0 + i), 1'(i == 2), 1'b1);
        @(negedge clk);
        chk("fill_count", 32'(fifo_count), 32'(4));
        chk("fill_ready", 32'(cmd_ready), 32'(0));
        wait_req();
        serve(1, 1'b1, 1'b0, 8'h00);
        rsp_check(0, rh);
        @(negedge clk);
        chk("fill_after_pop", 32'({cmd_ready, fifo_count}), 32'({1'b1, 3'd3}));
        for (int i = 1; i < 5; i++) begin
            wait_req();
            serve(2, 1'b1, 1'b0, 8'(8'h90 + i));
            rsp_check(0, rh);
        end
        chk("fill_drained", 32'({busy, fifo_count}), 32'(0));

        // Timeout: req high exactly 8 cycles
        push(SEL_SPI, 7'h33, 8'h11, 1'b1, 1'b1);
        wait_req();
        n = 0;
        do begin n++; @(negedge clk); end while (req && n < 300);
        chk("tmo_req_cycles", 32'(n), 32'(8));
        rsp_q.push_back('{data: 8'h00, err: 1'b1, tmo: 1'b1});
        rsp_check(1, rh);

        // Illegal selects: no req, select_p keeps last legal value
        push(3'b011, 7'h55, 8'h66, 1'b0, 1'b0);
        push(3'b000, 7'h56, 8'h67, 1'b1, 1'b0);
        rsp_check(0, rh);
        chk("ill1_no_req", 32'(rh), 32'(0));
        rsp_check(0, rh);
        chk("ill2_no_req", 32'(rh), 32'(0));
        chk("ill_sel_keep", 32'({req, select_p}), 32'({1'b0, SEL_SPI}));

        // ack and err together: err wins
        push(SEL_UART, 7'h12, 8'h34, 1'b1, 1'b1);
        wait_req();
        serve(2, 1'b1, 1'b1, 8'hEE);
        rsp_check(0, rh);

        // Reset while req is high, one command still queued
        push(SEL_I2C, 7'h61, 8'h71, 1'b0, 1'b1);
        push(SEL_UART, 7'h62, 8'h72, 1'b0, 1'b1);
        wait_req();
        chk("pre_rst_count", 32'(fifo_count), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req",  32'(req), 32'(0));
        chk("mid_rst_rspv", 32'(rsp_valid), 32'(0));
        chk("mid_rst_busy", 32'({busy, fifo_count}), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        iss_q.delete();
        rsp_q.delete();
        seen_req = 0; seen_rsp = 0;
        repeat (20) begin
            @(negedge clk);
            if (req) seen_req++;
            if (rsp_valid) seen_rsp++;
        end
        chk("post_rst_no_req", 32'(seen_req), 32'(0));
        chk("post_rst_no_rsp", 32'(seen_rsp), 32'(0));

        // Recovery after reset
        push(SEL_SPI, 7'h0F, 8'hF0, 1'b0, 1'b1);
        wait_req();
        serve(1, 1'b1, 1'b0, 8'h00);
        rsp_check(0, rh);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bus_txn_ctrl.md
Name: bus_txn_ctrl

Overview:
- Parametrised transaction controller between the command source and the serial protocol engines (UART/SPI/I2C).
- Replaces the fixed address/data/select bus. Commands (select, address, data, read/write) are buffered in a FIFO and issued one at a time to the engine selected by a one-hot select.
- Uses a req/ack handshake with timeout, captures read data and returns a response record.
- Sits between the top-level command logic and the protocol engines.

Parameters:
- ADDR_W, 7, address width.
- DATA_W, 8, data width.
- SEL_W, 3, protocol select width, one-hot; one bit per engine.
- DEPTH, 4, command FIFO depth; must be a power of 2 and at least 2.
- TIMEOUT, 255, maximum cycles req is held without ack/err; must be at least 1.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO not full.
- cmd_sel  in  SEL_W  one-hot engine select.
- cmd_addr  in  ADDR_W  target address.
- cmd_data  in  DATA_W  write data.
- cmd_rw  in  1  1=read, 0=write.
- select_p  out  SEL_W  registered engine select.
- address  out  ADDR_W  registered address to engine.
- data  out  DATA_W  registered write data to engine.
- rw  out  1  registered direction.
- req  out  1  transaction request to engine.
- ack  in  1  engine completed.
- err  in  1  engine failed (NACK, framing).
- received_data  in  DATA_W  engine read data, valid with ack.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_W  captured read data; 0 for writes and errors.
- rsp_err  out  1  engine err, timeout or illegal select.
- rsp_timeout  out  1  error cause was timeout.
- busy  out  1  FSM not IDLE or FIFO not empty.
- fifo_count  out  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (async, rst_n=0): all outputs are 0, FSM goes to IDLE, FIFO is empty.
- Mid-transaction reset: req drops immediately and the in-flight transaction is discarded with no response.
- FIFO push: occurs when cmd_valid & cmd_ready. cmd_ready = !full and does not depend on a same-cycle pop. Push and pop in the same cycle are both honoured and the count is unchanged. Pointers wrap modulo DEPTH.
- FSM states: IDLE, SETUP, REQ, RSP.
- IDLE:
  - If the FIFO is non-empty, pop the head and register select_p/address/data/rw.
  - If the head's cmd_sel is one-hot, go to SETUP.
  - Otherwise (0 or more than one bit set), go to RSP with rsp_err=1, rsp_data=0, and do not assert req.
  - On an illegal select, select_p keeps its previous value.
- SETUP: holds for one cycle so the engine mux settles, then goes to REQ with req=1.
- REQ:
  - req stays high. The timeout counter resets to 0 on entry and increments each cycle.
  - ack=1 & err=0: capture received_data if rw=1 (else rsp_data=0), rsp_err=0.
  - err=1: rsp_err=1, rsp_data=0. err wins over a same-cycle ack.
  - Counter reaching TIMEOUT-1 with no ack/err: rsp_err=1, rsp_timeout=1, rsp_data=0. An ack/err in the same cycle wins over the timeout.
  - On any exit, req deasserts the next cycle and the FSM goes to RSP with rsp_valid=1.
- RSP:
  - rsp_valid and the response fields hold until rsp_ready.
  - On handshake, go to IDLE, deassert rsp_valid and clear rsp_err/rsp_timeout.
  - rsp_data holds its value.
- select_p, address, data and rw change only on a pop and hold between transactions, with no glitch.
- Latency:
  - Command accepted at cycle N into an empty FIFO with idle FSM: pop and register at N+1, SETUP at N+1, req=1 at N+2.
  - ack sampled at cycle M gives rsp_valid=1 at M+1.
  - A back-to-back next pop occurs the cycle after the rsp handshake.
- ack/err outside REQ are ignored.

Decomposition:
- Package bus_pkg holds:
  - state enum {IDLE, SETUP, REQ, RSP};
  - one-hot constants SEL_UART=3'b001, SEL_SPI=3'b010, SEL_I2C=3'b100;
  - the FIFO entry struct {sel, addr, data, rw}.
- Sub-module bus_cmd_fifo: synchronous FIFO, width SEL_W+ADDR_W+DATA_W+1, depth DEPTH, with full/empty/count outputs.

Test Plan:
- Write: sel=001, addr=7'h42, data=8'hA4, rw=0, ack 3 cycles after req.
  - select_p=001, address=7'h42, data=8'hA4, req high for exactly 3 cycles.
  - rsp_valid with rsp_data=0, rsp_err=0.
- Read: sel=100, addr=7'h21, rw=1, ack with received_data=8'h5C.
  - rsp_data=8'h5C, rsp_err=0.
  - rsp held 4 cycles while rsp_ready=0, then cleared after handshake.
- Fill: 5 commands pushed back-to-back with DEPTH=4 and no ack.
  - cmd_ready low once fifo_count=4. The 5th command is accepted only after the first pop.
  - Commands are issued in order with correct addresses.
- Timeout: TIMEOUT=8, no ack.
  - req high for exactly 8 cycles, then rsp_err=1, rsp_timeout=1, rsp_data=0. The next command proceeds normally.
- Illegal select: sel=3'b011, then sel=000.
  - No req for either; each gives rsp_err=1, rsp_timeout=0.
  - select_p keeps its last legal value.
  - Then ack and err asserted together on a legal command: rsp_err=1.
- Reset mid-REQ: rst_n low for 1 cycle while req=1.
  - req, rsp_valid and busy are 0 immediately; fifo_count=0; no stale response after reset release.
